// File: rtl/ip_frame_feeder_if.sv
// Stream bus of the FFT front end: raw samples in, converted frame samples out.
// The slave modport is the feeder's view; the master modport is the producer/consumer side.
interface ip_frame_feeder_if #(
   parameter int IN_W  = 32,
   parameter int OUT_W = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_data;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_data;
   logic             out_sof;
   logic             out_eof;
   logic             ovf;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_sof, out_eof, ovf
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_sof, out_eof, ovf
   );
endinterface

// File: rtl/ip_frame_feeder.sv
// ip_frame_feeder: raw integer -> Q16.16 converter with a ping-pong frame buffer feeding the SDF FFT.
// Define SAT_EN to saturate out-of-range samples instead of wrapping them.
module ip_frame_feeder #(
   parameter int LENGTH = 8,
   parameter int IN_W   = 32,
   parameter int OUT_W  = 32,
   parameter int FRAC   = 16
)(
   input  logic             clk,
   input  logic             rst_n,
   ip_frame_feeder_if.slave bus
);
   localparam int IDX_W = $clog2(LENGTH);
   localparam int INT_W = OUT_W - FRAC;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LENGTH - 1);
   localparam logic signed [IN_W-1:0] RAW_MAX = IN_W'((2 ** (INT_W - 1)) - 1);
   localparam logic signed [IN_W-1:0] RAW_MIN = IN_W'(-(2 ** (INT_W - 1)));

   logic [OUT_W-1:0] r_mem [2][LENGTH];
   logic [1:0]       r_full;
   logic             r_wrBank;
   logic             r_rdBank;
   logic [IDX_W-1:0] r_wrIdx;
   logic [IDX_W-1:0] r_rdIdx;
   logic             r_ovf;

   logic             w_accept;
   logic             w_transfer;
   logic             w_tooBig;
   logic             w_tooSmall;
   logic [OUT_W-1:0] w_conv;

   assign bus.in_ready  = !r_full[r_wrBank];
   assign bus.out_valid = r_full[r_rdBank];
   assign bus.out_data  = r_mem[r_rdBank][r_rdIdx];
   assign bus.out_sof   = r_full[r_rdBank] && (r_rdIdx == '0);
   assign bus.out_eof   = r_full[r_rdBank] && (r_rdIdx == LAST_IDX);
   assign bus.ovf       = r_ovf;

   assign w_accept   = bus.in_valid && !r_full[r_wrBank];
   assign w_transfer = r_full[r_rdBank] && bus.out_ready;
   assign w_tooBig   = $signed(bus.in_data) > RAW_MAX;
   assign w_tooSmall = $signed(bus.in_data) < RAW_MIN;

   always_comb begin
      w_conv = {bus.in_data[INT_W-1:0], {FRAC{1'b0}}};
`ifdef SAT_EN
      if (w_tooBig)
         w_conv = {1'b0, {(INT_W-1){1'b1}}, {FRAC{1'b0}}};
      else if (w_tooSmall)
         w_conv = {1'b1, {(OUT_W-1){1'b0}}};
`endif
   end

   // Sample storage carries no reset: the full flags alone decide what is visible.
   always_ff @(posedge clk) begin
      if (w_accept)
         r_mem[r_wrBank][r_wrIdx] <= w_conv;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_full   <= '0;
         r_wrBank <= 1'b0;
         r_rdBank <= 1'b0;
         r_wrIdx  <= '0;
         r_rdIdx  <= '0;
         r_ovf    <= 1'b0;
      end else begin
         if (w_accept) begin
            r_wrIdx <= r_wrIdx + 1'b1;
            if (w_tooBig || w_tooSmall)
               r_ovf <= 1'b1;
            if (r_wrIdx == LAST_IDX) begin
               r_full[r_wrBank] <= 1'b1;
               r_wrBank         <= ~r_wrBank;
               r_wrIdx          <= '0;
            end
         end
         // The write side only ever fills the bank the read side is not draining.
         if (w_transfer) begin
            r_rdIdx <= r_rdIdx + 1'b1;
            if (r_rdIdx == LAST_IDX) begin
               r_full[r_rdBank] <= 1'b0;
               r_rdBank         <= ~r_rdBank;
               r_rdIdx          <= '0;
            end
         end
      end
   end
endmodule

// File: tb/tb_ip_frame_feeder.sv
// tb_ip_frame_feeder: table vectors, hand-written backpressure/reset sequences and a
// randomized phase checked against a queue-based frame model.
`timescale 1ns/1ps
module tb_ip_frame_feeder;
   localparam int LENGTH = 8;
   localparam int IN_W   = 32;
   localparam int OUT_W  = 32;
   localparam int FRAC   = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   ip_frame_feeder_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

   ip_frame_feeder #(
      .LENGTH(LENGTH), .IN_W(IN_W), .OUT_W(OUT_W), .FRAC(FRAC)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   typedef struct {
      logic [31:0] raw;
      logic [31:0] expOut;
   } vec_t;

   vec_t vecs [16];

   // Frame model: completed frames as a flat word queue plus the frame being assembled.
   logic [31:0] mOutQ [$];
   logic [31:0] mPart [$];
   int          mFrames;
   int          mRdPos;
   bit          mOvf;

   function automatic bit refOutOfRange(longint raw);
      return (raw > 32767) || (raw < -32768);
   endfunction

   function automatic logic [31:0] refConv(longint raw);
      longint shifted;
`ifdef SAT_EN
      if (raw > 32767)  return 32'h7FFF0000;
      if (raw < -32768) return 32'h80000000;
`endif
      shifted = raw * 65536;
      return shifted[31:0];
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic iv, input logic [31:0] data, input logic ordy);
      bus.in_valid  = iv;
      bus.in_data   = data;
      bus.out_ready = ordy;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] raw;
      bit          iv, ordy, expReady, expValid;

      vecs[0]  = '{32'd0,        32'h00000000};
      vecs[1]  = '{32'd1,        32'h00010000};
      vecs[2]  = '{32'd2,        32'h00020000};
      vecs[3]  = '{32'd3,        32'h00030000};
      vecs[4]  = '{32'd4,        32'h00040000};
      vecs[5]  = '{32'd5,        32'h00050000};
      vecs[6]  = '{32'd6,        32'h00060000};
      vecs[7]  = '{32'd7,        32'h00070000};
      vecs[8]  = '{32'hFFFFFFFF, 32'hFFFF0000};
      vecs[9]  = '{32'hFFFF8000, 32'h80000000};
      vecs[10] = '{32'd32767,    32'h7FFF0000};
      vecs[11] = '{32'd1,        32'h00010000};
      vecs[12] = '{32'hFFFFFFFE, 32'hFFFE0000};
      vecs[13] = '{32'd100,      32'h00640000};
`ifdef SAT_EN
      vecs[14] = '{32'd40000,    32'h7FFF0000};
      vecs[15] = '{32'hFFFF63C0, 32'h80000000};
`else
      vecs[14] = '{32'd40000,    32'h9C400000};
      vecs[15] = '{32'hFFFF63C0, 32'h63C00000};
`endif

      applyStimulus(1'b0, 32'h0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_in_ready", bus.in_ready, 1);
      checkOutput("rst_out_valid", bus.out_valid, 0);
      checkOutput("rst_sof", bus.out_sof, 0);
      checkOutput("rst_eof", bus.out_eof, 0);
      checkOutput("rst_ovf", bus.ovf, 0);
      rst_n = 1'b1;
      nextCycle();

      // Two back-to-back frames with the consumer always ready.
      for (int c = 0; c < 26; c++) begin
         applyStimulus(c < 16, (c < 16) ? vecs[c].raw : 32'h0, 1'b1);
         #3;
         checkOutput("tbl_in_ready", bus.in_ready, 1);
         checkOutput("tbl_out_valid", bus.out_valid, (c >= 8 && c < 24));
         if (c >= 8 && c < 24) begin
            checkOutput("tbl_out_data", bus.out_data, vecs[c-8].expOut);
            checkOutput("tbl_sof", bus.out_sof, ((c - 8) % 8) == 0);
            checkOutput("tbl_eof", bus.out_eof, ((c - 8) % 8) == 7);
         end
         checkOutput("tbl_ovf", bus.ovf, c >= 15);
         nextCycle();
      end

      // Consumer stalled: both banks fill, the 17th sample is refused.
      for (int k = 0; k < 17; k++) begin
         applyStimulus(1'b1, (k < 16) ? 32'(100 + k) : 32'd999, 1'b0);
         #3;
         checkOutput("bp_in_ready", bus.in_ready, k < 16);
         checkOutput("bp_out_valid", bus.out_valid, k >= 8);
         if (k >= 8) begin
            checkOutput("bp_hold_data", bus.out_data, 32'(100 * 65536));
            checkOutput("bp_hold_sof", bus.out_sof, 1);
            checkOutput("bp_hold_eof", bus.out_eof, 0);
         end
         nextCycle();
      end
      for (int d = 0; d < 17; d++) begin
         applyStimulus(d < 8, 32'd999, 1'b1);
         #3;
         checkOutput("bp_drain_in_ready", bus.in_ready, d >= 8);
         checkOutput("bp_drain_valid", bus.out_valid, d < 16);
         if (d < 16) begin
            checkOutput("bp_drain_data", bus.out_data, 32'((100 + d) * 65536));
            checkOutput("bp_drain_sof", bus.out_sof, (d % 8) == 0);
            checkOutput("bp_drain_eof", bus.out_eof, (d % 8) == 7);
         end
         nextCycle();
      end

      // A pending full frame plus three samples, then an asynchronous reset.
      for (int k = 0; k < 11; k++) begin
         applyStimulus(1'b1, 32'(500 + k), 1'b0);
         nextCycle();
      end
      applyStimulus(1'b0, 32'h0, 1'b0);
      rst_n = 1'b0;
      #2;
      checkOutput("mid_rst_out_valid", bus.out_valid, 0);
      checkOutput("mid_rst_in_ready", bus.in_ready, 1);
      checkOutput("mid_rst_ovf", bus.ovf, 0);
      checkOutput("mid_rst_sof", bus.out_sof, 0);
      nextCycle();
      rst_n = 1'b1;
      nextCycle();
      for (int c = 0; c < 17; c++) begin
         applyStimulus(c < 8, 32'(-20 + 7 * c), 1'b1);
         #3;
         checkOutput("post_rst_valid", bus.out_valid, (c >= 8 && c < 16));
         if (c >= 8 && c < 16) begin
            checkOutput("post_rst_data", bus.out_data, 32'((-20 + 7 * (c - 8)) * 65536));
            checkOutput("post_rst_sof", bus.out_sof, c == 8);
            checkOutput("post_rst_eof", bus.out_eof, c == 15);
         end
         checkOutput("post_rst_ovf", bus.ovf, 0);
         nextCycle();
      end

      // Randomized traffic against the frame model (starts from an empty, clean state).
      mOutQ.delete();
      mPart.delete();
      mFrames = 0;
      mRdPos  = 0;
      mOvf    = 1'b0;
      for (int n = 0; n < 800; n++) begin
         iv   = ($urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 9) < 6);
         if ($urandom_range(0, 9) == 0)
            raw = $urandom();
         else
            raw = 32'(int'($urandom_range(0, 65535)) - 32768);
         applyStimulus(iv, raw, ordy);
         #3;
         expReady = (mFrames < 2);
         expValid = (mFrames > 0);
         checkOutput("rnd_in_ready", bus.in_ready, expReady);
         checkOutput("rnd_out_valid", bus.out_valid, expValid);
         if (expValid) begin
            checkOutput("rnd_out_data", bus.out_data, mOutQ[0]);
            checkOutput("rnd_sof", bus.out_sof, mRdPos == 0);
            checkOutput("rnd_eof", bus.out_eof, mRdPos == LENGTH - 1);
         end
         checkOutput("rnd_ovf", bus.ovf, mOvf);
         nextCycle();
         if (expValid && ordy) begin
            void'(mOutQ.pop_front());
            mRdPos++;
            if (mRdPos == LENGTH) begin
               mRdPos = 0;
               mFrames--;
            end
         end
         if (iv && expReady) begin
            mPart.push_back(refConv(longint'($signed(raw))));
            if (refOutOfRange(longint'($signed(raw))))
               mOvf = 1'b1;
            if (mPart.size() == LENGTH) begin
               foreach (mPart[i]) mOutQ.push_back(mPart[i]);
               mPart.delete();
               mFrames++;
            end
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
